irom_boot_loader: RTL

Instruction-memory responder for the five-stage core. It owns the instruction store and answers the core's word-address fetch port (`pc` in, `instr` out) combinationally. It also fills that store from a byte-stream boot port using a framed length/payload/checksum protocol. The core is held in reset until a complete, checksum-valid image has been written.

---
 rtl/boot_pkg.sv | 15 +
 rtl/irom_array.sv | 23 ++
 rtl/irom_boot_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-ROM boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } boot_state_e;

  localparam int unsigned BOOT_HDR_BYTES = 4;
  localparam logic [31:0] BOOT_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/irom_array.sv
// Single write port, asynchronous read 32-bit instruction store; no reset so contents survive rst_n.
module irom_array #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/irom_boot_loader.sv
// Instruction store plus framed byte-stream loader; holds the core in reset until a
// checksum-valid image (length, payload, XOR checksum) has been written.
module irom_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] NOP_INSTR  = BOOT_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instr,
  input  logic                  boot_valid,
  input  logic [7:0]            boot_data,
  output logic                  boot_ready,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_N  = CW'(1) << ADDR_WIDTH;
  localparam logic [1:0] LAST_BYTE = 2'(BOOT_HDR_BYTES - 1);

  boot_state_e           state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            xor_q, xor_d;
  logic [23:0]           wbuf_q, wbuf_d;
  logic                  boot_ready_q, cpu_rst_n_q, load_done_q, load_err_q;

  logic                  we_c;
  logic [31:0]           wdata_c;
  logic [31:0]           hdr_shift_c;
  logic [31:0]           rdata_c;

  // Next-state, counters, checksum and store-write strobe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_addr_d   = wr_addr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    xor_d       = xor_q;
    wbuf_d      = wbuf_q;
    we_c        = 1'b0;
    wdata_c     = {boot_data, wbuf_q};
    hdr_shift_c = 32'(boot_data) << {idx_q, 3'b000};

    case (state_q)
      HDR: begin
        if (boot_valid) begin
          // Bits beyond the count register only matter as "too large".
          cnt_d = cnt_q | CW'(hdr_shift_c);
          ovf_d = ovf_q | (|(hdr_shift_c >> CW));
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_BYTE) begin
            if (ovf_d || (cnt_d == '0) || (cnt_d > MAX_N)) state_d = ERR;
            else                                            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (boot_valid) begin
          wbuf_d = {boot_data, wbuf_q[23:8]};
          xor_d  = xor_q ^ boot_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == LAST_BYTE) begin
            we_c      = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            if (wr_addr_q == ADDR_WIDTH'(cnt_q - CW'(1))) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (boot_valid) state_d = (boot_data == xor_q) ? RUN : ERR;
      end
      default: ;
    endcase
  end

  // State and flag registers; flags follow the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HDR;
      idx_q        <= '0;
      wr_addr_q    <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      xor_q        <= '0;
      wbuf_q       <= '0;
      boot_ready_q <= 1'b1;
      cpu_rst_n_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_addr_q    <= wr_addr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      xor_q        <= xor_d;
      wbuf_q       <= wbuf_d;
      boot_ready_q <= (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
      cpu_rst_n_q  <= (state_d == RUN);
      load_done_q  <= (state_d == RUN);
      load_err_q   <= (state_d == ERR);
    end
  end

  irom_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (we_c),
    .waddr(wr_addr_q),
    .wdata(wdata_c),
    .raddr(pc),
    .rdata(rdata_c)
  );

  assign instr      = (state_q == RUN) ? rdata_c : NOP_INSTR;
  assign boot_ready = boot_ready_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
